fir_decim_buffer: RTL

//   Downstream stage of the FIR filter. Re-times the filter's sample enable to the

---
 rtl/fir_decim_buffer_pkg.sv | 14 +
 rtl/fir_decim_buffer_sync_fifo.sv | 78 +++++++
 rtl/fir_decim_buffer.sv | 109 ++++++++++
 3 files changed

// File: rtl/fir_decim_buffer_pkg.sv
// Shared constants for the FIR output stage and the clog2 helper that sizes o_level.
// FIR_PIPE_LAT must track the pipeline depth of the upstream filter.
package fir_decim_buffer_pkg;
  localparam int FIR_PIPE_LAT   = 3;
  localparam int FIR_WW_OUTPUT  = 8;
  localparam int FIR_FIFO_DEPTH = 8;

  function automatic int fir_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/fir_decim_buffer_sync_fifo.sv
// Single-clock FIFO with a registered head: a write into an empty FIFO is visible next clock.
// Writes while full are ignored unless a read happens in the same clock; reads while empty are ignored.
module sync_fifo
  import fir_decim_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      i_srst,
  input  logic                      i_wr,
  input  logic [WIDTH-1:0]          i_wdata,
  input  logic                      i_rd,
  output logic [WIDTH-1:0]          o_head,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [fir_clog2(DEPTH):0] o_level
);
  localparam int AW = fir_clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    rd_nxt;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             rd, wr;

  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LVL_FULL);
  assign rd      = i_rd & ~o_empty;
  assign wr      = i_wr & (~o_full | rd);
  assign rd_nxt  = rd_ptr_q + AW'(1);

  always_comb begin
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_nxt : rd_ptr_q;
    level_d  = level_q;
    if (wr && !rd)
      level_d = level_q + LW'(1);
    else if (rd && !wr)
      level_d = level_q - LW'(1);
    // Head is pre-fetched so o_head never depends on this cycle's read request.
    head_d = head_q;
    if (rd) begin
      if (level_q > LW'(1))
        head_d = mem_q[rd_nxt];
      else if (wr)
        head_d = i_wdata;
    end else if (wr && o_empty) begin
      head_d = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (i_srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wr_ptr_q] <= i_wdata;
  end

  assign o_head  = head_q;
  assign o_level = level_q;
endmodule

// File: rtl/fir_decim_buffer.sv
// FIR output stage: re-times the filter enable by PIPE_LAT, keeps 1 of (i_decim+1) strobes, buffers in a FIFO.
// Kept sample visible one clock after capture; stalls drop samples (sticky o_overflow, o_drop_cnt with FIR_DECIM_DROP_CNT_EN).
module fir_decim_buffer
  import fir_decim_buffer_pkg::*;
#(
  parameter int WW_DATA    = FIR_WW_OUTPUT,
  parameter int PIPE_LAT   = FIR_PIPE_LAT,
  parameter int FIFO_DEPTH = FIR_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           i_srst,
  input  logic                           i_en,
  input  logic [WW_DATA-1:0]             i_data,
  input  logic [3:0]                     i_decim,
  output logic [WW_DATA-1:0]             o_data,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [fir_clog2(FIFO_DEPTH):0] o_level,
  output logic                           o_overflow
`ifdef FIR_DECIM_DROP_CNT_EN
  ,
  output logic [15:0]                    o_drop_cnt
`endif
);
  logic [PIPE_LAT-1:0] en_dly_q, en_dly_d;
  logic [3:0]          phase_q, phase_d;
  logic [3:0]          dec_q, dec_d;
  logic                ovf_q, ovf_d;
  logic                strobe, keep, rd, wr, drop;
  logic                fifo_empty, fifo_full;

  assign strobe = en_dly_q[PIPE_LAT-1];
  assign keep   = strobe & (phase_q == 4'd0);
  assign rd     = i_ready & ~fifo_empty;
  assign wr     = keep & (~fifo_full | rd);
  assign drop   = keep & fifo_full & ~rd;

  always_comb begin
    en_dly_d    = en_dly_q << 1;
    en_dly_d[0] = i_en;
  end

  // The decimation factor is only re-sampled at a period boundary.
  always_comb begin
    phase_d = phase_q;
    dec_d   = dec_q;
    if (strobe) begin
      if (phase_q == dec_q) begin
        phase_d = '0;
        dec_d   = i_decim;
      end else begin
        phase_d = phase_q + 4'd1;
      end
    end
  end

  assign ovf_d = ovf_q | drop;

  always_ff @(posedge clk) begin
    if (i_srst) begin
      en_dly_q <= '0;
      phase_q  <= '0;
      dec_q    <= i_decim;
      ovf_q    <= 1'b0;
    end else begin
      en_dly_q <= en_dly_d;
      phase_q  <= phase_d;
      dec_q    <= dec_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef FIR_DECIM_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (i_srst)
      drop_cnt_q <= '0;
    else
      drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  sync_fifo #(
    .WIDTH (WW_DATA),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_srst  (i_srst),
    .i_wr    (wr),
    .i_wdata (i_data),
    .i_rd    (rd),
    .o_head  (o_data),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_level (o_level)
  );

  assign o_valid    = ~fifo_empty;
  assign o_overflow = ovf_q;
endmodule
